// File: rtl/mips_mem_pkg.sv
// Shared definitions for the Harvard data-side RAM.
//   DEPTH_WORDS_DEFAULT : default number of 32-bit words
//   BASE_ADDR_DEFAULT   : default byte address of word 0
//   WORD_W / CNT_W      : data word and access-counter widths
//   index_width()       : word-index width for a given depth
package mips_mem_pkg;

  localparam int          DEPTH_WORDS_DEFAULT = 256;
  localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'h0000_1000;
  localparam int          WORD_W              = 32;
  localparam int          CNT_W               = 16;

  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_array.sv
// Word-wide storage with one synchronous write port and one asynchronous
// read port. Contents are never cleared, so an image loaded before reset
// survives it. A read of the word being written in the same cycle returns
// the old contents because the write only lands at the clock edge.
//   clk    : write clock
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data (combinational)
module ram_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_WORDS_DEFAULT,
  parameter int IDX_W  = index_width(DEPTH_WORDS_DEFAULT),
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/harvard_data_ram.sv
// Data-side RAM for a Harvard CPU with a side-band loader port.
// The CPU sees a byte-addressed window of DEPTH_WORDS words starting at
// BASE_ADDR; the loader writes by word index whenever the CPU is not
// writing. Misaligned and out-of-window accesses raise sticky flags, and
// accepted reads/writes are counted with saturating counters.
//   clk, reset      : clock, synchronous active-high reset
//   clk_enable      : global advance enable from the CPU side
//   data_address    : CPU byte address
//   data_write/read : CPU strobes
//   data_writedata  : CPU write data
//   data_readdata   : CPU read data (combinational, zero when not a valid read)
//   load_valid/addr/data : loader request (held until accepted)
//   load_ready      : loader accept (combinational)
//   err_misaligned  : sticky misaligned-access flag
//   err_range       : sticky out-of-window flag
//   rd_count/wr_count : saturating counts of accepted CPU reads/writes
module harvard_data_ram
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clk_enable,
  input  logic [31:0]                           data_address,
  input  logic                                  data_write,
  input  logic                                  data_read,
  input  logic [WORD_W-1:0]                     data_writedata,
  output logic [WORD_W-1:0]                     data_readdata,
  input  logic                                  load_valid,
  input  logic [index_width(DEPTH_WORDS)-1:0]   load_addr,
  input  logic [WORD_W-1:0]                     load_data,
  output logic                                  load_ready,
  output logic                                  err_misaligned,
  output logic                                  err_range,
  output logic [CNT_W-1:0]                      rd_count,
  output logic [CNT_W-1:0]                      wr_count
);

  localparam int          IDX_W        = index_width(DEPTH_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [31:0]       offset;
  logic              aligned;
  logic              in_window;
  logic              valid;
  logic              access;
  logic [IDX_W-1:0]  cpu_index;
  logic              cpu_we;
  logic              load_we;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  // Address decode: the offset is taken modulo 2^32, so addresses below
  // BASE_ADDR wrap to large values; the explicit lower-bound test keeps that
  // from ever aliasing into the window.
  assign offset    = data_address - BASE_ADDR;
  assign aligned   = (data_address[1:0] == 2'b00);
  assign in_window = (data_address >= BASE_ADDR) && (offset < WINDOW_BYTES);
  assign valid     = aligned && in_window;
  assign access    = data_read || data_write;
  assign cpu_index = offset[IDX_W+1:2];

  // Write arbitration: a valid CPU write owns the single write port; the
  // loader is only offered the port when that is not happening.
  assign cpu_we     = clk_enable && !reset && data_write && valid;
  assign load_ready = clk_enable && !reset && !(data_write && valid);
  assign load_we    = load_valid && load_ready;

  assign ram_we    = cpu_we || load_we;
  assign ram_waddr = cpu_we ? cpu_index : load_addr;
  assign ram_wdata = cpu_we ? data_writedata : load_data;

  ram_array #(
    .DEPTH  (DEPTH_WORDS),
    .IDX_W  (IDX_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cpu_index),
    .rdata (ram_rdata)
  );

  assign data_readdata = (data_read && valid) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count       <= '0;
      wr_count       <= '0;
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
    end else if (clk_enable) begin
      if (access && !aligned) begin
        err_misaligned <= 1'b1;
      end
      if (access && aligned && !in_window) begin
        err_range <= 1'b1;
      end
      if (data_read && valid) begin
        rd_count <= sat_inc(rd_count);
      end
      if (data_write && valid) begin
        wr_count <= sat_inc(wr_count);
      end
    end
  end

endmodule

// File: tb/tb_harvard_data_ram.sv
module tb_harvard_data_ram;
  import mips_mem_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        load_valid;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        err_misaligned;
  logic        err_range;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  harvard_data_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        ready;
    logic [15:0] rc;
    logic [15:0] wc;
    logic        em;
    logic        er;
    bit          chk_rdata;
    bit          chk_regs;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a plain word array plus counters and flags.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_rc = 0;
  int          m_wc = 0;
  bit          m_em = 0;
  bit          m_er = 0;
  bit          m_regs_known = 0;
  bit          last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input logic [31:0] addr,
                       input bit rd, input bit wr, input logic [31:0] wd,
                       input bit lv, input int la, input logic [31:0] ld);
    longint a;
    bit     v;
    int     idx;
    bit     rdy;
    exp_t   e;
    @(negedge clk);
    reset          = rst;
    clk_enable     = en;
    data_address   = addr;
    data_read      = rd;
    data_write     = wr;
    data_writedata = wd;
    load_valid     = lv;
    load_addr      = 8'(la);
    load_data      = ld;

    a   = longint'(addr);
    v   = (a % 4 == 0) && (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
    idx = v ? int'((a - longint'(BASE)) / 4) : 0;
    rdy = en && !rst && !(wr && v);

    e.ready     = rdy;
    e.rdata     = (rd && v) ? m_mem[idx] : 32'h0;
    e.chk_rdata = !(rd && v) || m_known[idx];
    e.rc        = 16'(m_rc);
    e.wc        = 16'(m_wc);
    e.em        = m_em;
    e.er        = m_er;
    e.chk_regs  = m_regs_known;
    sbq.push_back(e);
    last_ready = rdy;

    if (rst) begin
      m_rc = 0; m_wc = 0; m_em = 0; m_er = 0;
      m_regs_known = 1;
    end else if (en) begin
      if (wr && v) begin
        m_mem[idx] = wd; m_known[idx] = 1;
      end
      if (lv && rdy) begin
        m_mem[la] = ld; m_known[la] = 1;
      end
      if ((rd || wr) && (a % 4 != 0)) m_em = 1;
      if ((rd || wr) && (a % 4 == 0) && !v) m_er = 1;
      if (rd && v && m_rc < 65535) m_rc++;
      if (wr && v && m_wc < 65535) m_wc++;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    if (s < 8) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    if (s == 8) return BASE - 32'(4 * $urandom_range(1, 4));
    return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
  endfunction

  // Monitor: compares each presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        check("load_ready", {31'b0, load_ready}, {31'b0, mon_e.ready});
        if (mon_e.chk_rdata) check("data_readdata", data_readdata, mon_e.rdata);
        if (mon_e.chk_regs) begin
          check("rd_count", {16'b0, rd_count}, {16'b0, mon_e.rc});
          check("wr_count", {16'b0, wr_count}, {16'b0, mon_e.wc});
          check("err_misaligned", {31'b0, err_misaligned}, {31'b0, mon_e.em});
          check("err_range", {31'b0, err_range}, {31'b0, mon_e.er});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    bit          pend;
    int          paddr;
    logic [31:0] pdata;
    bit          rst;
    bit          en;
    bit          rd;
    bit          wr;

    reset = 1'b1; clk_enable = 1'b0; data_address = '0; data_read = 1'b0;
    data_write = 1'b0; data_writedata = '0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Fill the whole array through the loader.
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 0, 0, 1, i, $urandom);

    // Loader word then CPU read of it.
    cycle(0, 1, 0, 0, 0, 0, 1, 3, 32'hDEAD_BEEF);
    cycle(0, 1, 32'h0000_100C, 1, 0, 0, 0, 0, 0);

    // Same-cycle read+write of one word returns the old value first.
    cycle(0, 1, 0, 0, 0, 0, 1, 0, 32'h0000_000A);
    cycle(0, 1, 32'h0000_1000, 1, 1, 32'h0000_000B, 0, 0, 0);
    cycle(0, 1, 32'h0000_1000, 1, 0, 0, 0, 0, 0);

    // CPU write beats the loader; loader is taken the next cycle.
    cycle(0, 1, 32'h0000_1010, 0, 1, 32'h1234_5678, 1, 4, 32'hFFFF_FFFF);
    cycle(0, 1, 32'h0000_1010, 1, 0, 0, 1, 4, 32'hFFFF_FFFF);
    cycle(0, 1, 32'h0000_1010, 1, 0, 0, 0, 0, 0);

    // Stalled write does nothing.
    cycle(0, 0, 32'h0000_1004, 0, 1, 32'h5555_AAAA, 1, 7, 32'h0BAD_0BAD);
    cycle(0, 1, 32'h0000_1004, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000_101C, 1, 0, 0, 0, 0, 0);

    // Window edges and error flags.
    cycle(0, 1, 32'h0000_13FC, 1, 1, 32'hCAFE_F00D, 0, 0, 0);
    cycle(0, 1, 32'h0000_13FC, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000_1002, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000_1400, 0, 1, 32'h7777_7777, 0, 0, 0);
    cycle(0, 1, 32'h0000_0FFC, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000_13FC, 1, 0, 0, 0, 0, 0);

    // Saturate the read counter.
    for (int i = 0; i < 65600; i++) cycle(0, 1, 32'h0000_100C, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 1, 3, 32'h0);
    cycle(0, 1, 32'h0000_100C, 1, 0, 0, 0, 0, 0);

    // Random traffic with a loader that holds its request until accepted.
    pend = 0; paddr = 0; pdata = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend = 1; paddr = $urandom_range(0, DEPTH - 1); pdata = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      rd  = $urandom_range(0, 1);
      wr  = ($urandom_range(0, 2) == 0);
      cycle(rst, en, rand_addr(), rd, wr, $urandom, pend, paddr, pdata);
      if (pend && last_ready) pend = 0;
    end
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
